// File: rtl/nios_simple_cpu_mul_ctrl_if.sv
// Bus between the CPU pipeline / multiply cell and the multiply control stage.
// The master side is the pipeline plus the cell; the slave side is the controller.
interface nios_simple_cpu_mul_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              mul_req;
    logic              mul_kill;
    logic [DATA_W-1:0] mul_src1;
    logic [DATA_W-1:0] mul_src2;
    logic [DATA_W-1:0] A_mul_cell_result;
    logic [DATA_W-1:0] A_mul_src1;
    logic [DATA_W-1:0] A_mul_src2;
    logic              mul_stall;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;

    modport master (
        output mul_req,
        output mul_kill,
        output mul_src1,
        output mul_src2,
        output A_mul_cell_result,
        input  A_mul_src1,
        input  A_mul_src2,
        input  mul_stall,
        input  mul_done,
        input  mul_result
    );

    modport slave (
        input  mul_req,
        input  mul_kill,
        input  mul_src1,
        input  mul_src2,
        input  A_mul_cell_result,
        output A_mul_src1,
        output A_mul_src2,
        output mul_stall,
        output mul_done,
        output mul_result
    );
endinterface

// File: rtl/nios_simple_cpu_mul_ctrl.sv
// Multi-cycle multiply control: registers operands onto the cell inputs, waits out the
// cell latency, captures the low product word and pulses done while stalling the pipeline.
module nios_simple_cpu_mul_ctrl #(
    parameter int unsigned CELL_LAT = 1,
    parameter int unsigned DATA_W   = 32
) (
    input logic                       clk,
    input logic                       reset_n,
    nios_simple_cpu_mul_ctrl_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StCapt = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned     CntW    = 3;
    localparam logic [CntW-1:0] CntLoad = CntW'(CELL_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        res_d   = res_q;
        done_d  = 1'b0;
        // Kill wins over accept and capture alike; the held result is left untouched.
        if (bus.mul_kill) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.mul_req) begin
                        src1_d  = bus.mul_src1;
                        src2_d  = bus.mul_src2;
                        cnt_d   = CntLoad;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_d = StCapt;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StCapt: begin
                    res_d   = bus.A_mul_cell_result;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
                StDone: begin
                    // The request still high here belongs to the completed instruction.
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign bus.A_mul_src1 = src1_q;
    assign bus.A_mul_src2 = src2_q;
    assign bus.mul_result = res_q;
    assign bus.mul_done   = done_q;
    assign bus.mul_stall  = bus.mul_req & ~done_q & ~bus.mul_kill;
endmodule

// File: tb/tb_nios_simple_cpu_mul_ctrl.sv
// Bench for the multiply control stage: a CELL_LAT=1 and a CELL_LAT=3 instance share stimulus,
// each checked every cycle against a transaction-age reference model.
module tb_nios_simple_cpu_mul_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_r = 1'b0;
    logic        kill_r = 1'b0;
    logic [31:0] s1_r = '0;
    logic [31:0] s2_r = '0;

    always #5 clk = ~clk;

    nios_simple_cpu_mul_ctrl_if #(.DATA_W(32)) bus0 ();
    nios_simple_cpu_mul_ctrl_if #(.DATA_W(32)) bus1 ();

    assign bus0.mul_req  = req_r;
    assign bus0.mul_kill = kill_r;
    assign bus0.mul_src1 = s1_r;
    assign bus0.mul_src2 = s2_r;
    assign bus1.mul_req  = req_r;
    assign bus1.mul_kill = kill_r;
    assign bus1.mul_src1 = s1_r;
    assign bus1.mul_src2 = s2_r;

    nios_simple_cpu_mul_ctrl #(.CELL_LAT(1), .DATA_W(32)) dut0 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus0)
    );

    nios_simple_cpu_mul_ctrl #(.CELL_LAT(3), .DATA_W(32)) dut1 (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus1)
    );

    // Multiply cells: one and three register stages after the operand inputs.
    logic [31:0] cell0_q = '0;
    logic [31:0] cell1_q [3] = '{default: '0};
    always @(posedge clk) begin
        cell0_q    <= bus0.A_mul_src1 * bus0.A_mul_src2;
        cell1_q[0] <= bus1.A_mul_src1 * bus1.A_mul_src2;
        cell1_q[1] <= cell1_q[0];
        cell1_q[2] <= cell1_q[1];
    end
    assign bus0.A_mul_cell_result = cell0_q;
    assign bus1.A_mul_cell_result = cell1_q[2];

    // Reference model: an accepted operation is tracked by its age in cycles since acceptance.
    int          lat [2] = '{1, 3};
    bit          busy [2];
    int          age [2];
    logic [31:0] ma [2];
    logic [31:0] mb [2];
    logic [31:0] mres [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0;
            age[i]  = 0;
            ma[i]   = '0;
            mb[i]   = '0;
            mres[i] = '0;
        end
    endtask

    task automatic check_dut(input int i, input logic stall, input logic done,
                             input logic [31:0] res, input logic [31:0] a,
                             input logic [31:0] b);
        logic ed;
        ed = busy[i] && (age[i] == lat[i] + 2);
        chk($sformatf("dut%0d_stall_c%0d", i, cyc), {31'd0, stall},
            {31'd0, req_r & ~ed & ~kill_r});
        chk($sformatf("dut%0d_done_c%0d", i, cyc), {31'd0, done}, {31'd0, ed});
        chk($sformatf("dut%0d_result_c%0d", i, cyc), res, mres[i]);
        chk($sformatf("dut%0d_src1_c%0d", i, cyc), a, ma[i]);
        chk($sformatf("dut%0d_src2_c%0d", i, cyc), b, mb[i]);
    endtask

    task automatic model_edge(input int i);
        if (kill_r) begin
            busy[i] = 1'b0;
        end else if (busy[i]) begin
            if (age[i] == lat[i] + 1) mres[i] = ma[i] * mb[i];
            if (age[i] == lat[i] + 2) busy[i] = 1'b0;
            else age[i] = age[i] + 1;
        end else if (req_r) begin
            busy[i] = 1'b1;
            age[i]  = 1;
            ma[i]   = s1_r;
            mb[i]   = s2_r;
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model at the rise.
    task automatic cycle(input logic req, input logic kill, input logic [31:0] s1,
                         input logic [31:0] s2);
        req_r  = req;
        kill_r = kill;
        s1_r   = s1;
        s2_r   = s2;
        @(negedge clk);
        check_dut(0, bus0.mul_stall, bus0.mul_done, bus0.mul_result, bus0.A_mul_src1,
                  bus0.A_mul_src2);
        check_dut(1, bus1.mul_stall, bus1.mul_done, bus1.mul_result, bus1.A_mul_src1,
                  bus1.A_mul_src2);
        done0_cnt += int'(bus0.mul_done);
        done1_cnt += int'(bus1.mul_done);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_d0_src1"}, bus0.A_mul_src1, 32'd0);
        chk({tag, "_d0_src2"}, bus0.A_mul_src2, 32'd0);
        chk({tag, "_d0_result"}, bus0.mul_result, 32'd0);
        chk({tag, "_d0_done"}, {31'd0, bus0.mul_done}, 32'd0);
        chk({tag, "_d1_src1"}, bus1.A_mul_src1, 32'd0);
        chk({tag, "_d1_src2"}, bus1.A_mul_src2, 32'd0);
        chk({tag, "_d1_result"}, bus1.mul_result, 32'd0);
        chk({tag, "_d1_done"}, {31'd0, bus1.mul_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1 reset_checks("reset");
        chk("reset_stall", {31'd0, bus0.mul_stall}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic: 0x0001_0003 * 5, done in cycle 3.
        done0_cnt = 0;
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 32'h0001_0003, 32'h0000_0005);
        chk("basic_done_count", done0_cnt, 1);
        chk("basic_result", bus0.mul_result, 32'h0005_000F);
        idle(4);

        // Wrap and unsigned low word.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("wrap_ff_result", bus0.mul_result, 32'h0000_0001);
        idle(4);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0002);
        chk("wrap_80_result", bus0.mul_result, 32'h0000_0000);
        idle(4);

        // Operand change after acceptance is ignored.
        cycle(1'b1, 1'b0, 32'd7, 32'd6);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h1234, 32'd6);
        chk("opchg_result", bus0.mul_result, 32'h0000_002A);
        chk("opchg_src1_held", bus0.A_mul_src1, 32'd7);
        idle(4);
        chk("opchg_src1_still", bus0.A_mul_src1, 32'd7);

        // Kill in WAIT, then an immediate new request.
        done0_cnt = 0;
        cycle(1'b1, 1'b0, 32'd3, 32'd3);
        cycle(1'b1, 1'b1, 32'd3, 32'd3);
        chk("kill_result_kept", bus0.mul_result, 32'h0000_002A);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 32'd4, 32'd5);
        chk("kill_done_count", done0_cnt, 1);
        chk("kill_next_result", bus0.mul_result, 32'd20);
        idle(4);

        // Back-to-back: accepts at 0,4,8 with done at 3,7,11.
        done0_cnt = 0;
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, $urandom, $urandom);
        chk("b2b_done_count", done0_cnt, 3);
        idle(6);

        // CELL_LAT=3 instance: 0x10*0x10, done in cycle 5.
        done1_cnt = 0;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 32'h10, 32'h10);
        chk("lat3_done_count", done1_cnt, 1);
        chk("lat3_result", bus1.mul_result, 32'h100);
        idle(5);

        // Asynchronous reset between edges during WAIT.
        cycle(1'b1, 1'b0, 32'd9, 32'd9);
        req_r = 1'b0;
        #1 reset_n = 1'b0;
        #1 reset_checks("async");
        model_reset();
        #1 reset_n = 1'b1;
        done0_cnt = 0;
        done1_cnt = 0;
        idle(6);
        chk("async_no_done0", done0_cnt, 0);
        chk("async_no_done1", done1_cnt, 0);

        // Randomized traffic with occasional kills and protocol-violating request drops.
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
                  $urandom);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
